merge2_arbiter: RTL and testbench
=================================

Name: merge2_arbiter

Overview:
- Downstream neighbour of the leaf/branch address decoders in the NoC tree.
- Merges two packet streams (e.g. the Out1 "not-for-me" streams of two sibling decoders) onto one upward-going link toward the parent node.
- Arbitration between the two inputs is fair round-robin. Each accepted packet is queued in a small FIFO together with a 1-bit winner tag, the merge-side counterpart of the decoder's S select channel.
- Clocked RTL body. Channels use a valid/ready handshake; the channel wrapper converts these to 1-of-N channels.

Parameters:
W, 9, packet width in bits; bits [8:5] are the 4-bit destination address, carried through unmodified.
DEPTH, 2, output FIFO entries; must be ≥2, power of two not required.

Ports:
CLK  in  1  clock, all state updates on posedge
_RESET  in  1  asynchronous active-low reset
In0_data  in  W  packet from input 0
In0_valid  in  1  input 0 offers a packet
In0_ready  out  1  input 0 packet accepted this cycle
In1_data  in  W  packet from input 1
In1_valid  in  1  input 1 offers a packet
In1_ready  out  1  input 1 packet accepted this cycle
Out_data  out  W  head-of-FIFO packet
Out_win  out  1  head packet's source: 0 = In0, 1 = In1
Out_valid  out  1  FIFO non-empty
Out_ready  in  1  consumer accepts head

Behaviour:
- Clock and reset: one clock CLK. Reset _RESET is asynchronous, active-low.
- Reset state:
  - FIFO empty (count = 0, rd_ptr = wr_ptr = 0).
  - prio = 0, so In0 is favoured first.
  - Out_valid = 0; Out_data = 0; Out_win = 0.
  - In0_ready = In1_ready = 0 while _RESET is low.
- Transfer rule: a transfer occurs on a posedge where valid && ready are both high. Data is sampled on that edge.
- Space: space = (count < DEPTH).
  - Space is computed from registered count only. There is no combinational path from Out_ready to In*_ready.
- Grant (combinational, at most one grant per cycle):
  - If !space: no grant.
  - If only In0_valid: grant 0. If only In1_valid: grant 1.
  - If both are valid: grant = prio.
  - In_k_ready = grant_k. Ready may depend on the same input's valid; upstream must not make valid depend on ready.
- Priority update: on a granted transfer, prio <= ~grant_index, so the loser of a tie wins next time. With no transfer, prio is held.
- Push: the FIFO entry {grant_index, In_grant_data} is written at wr_ptr. wr_ptr wraps to 0 after DEPTH-1.
- Pop: when Out_valid && Out_ready, rd_ptr advances and wraps the same way.
- Count: count += push - pop. Simultaneous push and pop leaves count unchanged.
  - Push is legal when count == DEPTH-1 together with a pop.
  - At count == DEPTH, no push occurs even if a pop happens that cycle; the grant is lost for that cycle.
- Outputs: Out_data and Out_win are read from the FIFO head (registered storage). Output is valid the cycle after a push.
- Latency and throughput:
  - Latency from input transfer to Out_valid is 1 cycle.
  - With Out_ready held high, sustained throughput is 1 packet per cycle.
  - Two valid inputs alternate 0,1,0,1…
- Stability:
  - Out_data and Out_win are stable while Out_valid && !Out_ready.
  - Packet order is preserved per input and globally in grant order.
- Reset mid-operation: queued packets are discarded, prio returns to 0, and all outputs go to their reset values immediately (asynchronously).
- Packet contents are never modified; Out_data equals the accepted In_data bit-for-bit.

Decomposition:
- Shared NoC package holds:
  - PKT_W = 9
  - ADDR_MSB = 8, ADDR_LSB = 5
  - a packed typedef merge_entry_t = {logic win; logic [PKT_W-1:0] data;}
- One natural sub-module: merge_fifo (parameterised DEPTH sync FIFO with count, full and empty).
- The round-robin grant logic stays in merge2_arbiter.

Test Plan:
1. Reset with both inputs valid (In0 = 9'h1A3, In1 = 9'h0F2) -> during reset: both readies 0, Out_valid 0. After release: first grant In0, then Out = 9'h1A3/win 0 on the next cycle, followed by 9'h0F2/win 1.
2. Both inputs continuously valid, Out_ready = 1, 8 cycles -> outputs strictly alternate win 0,1,0,1…; 1 packet/cycle after the first; no packet duplicated or dropped.
3. Out_ready = 0, In0 streaming 9'h101, 9'h102, 9'h103 ->
   - first two packets accepted; FIFO full at count = 2.
   - In0_ready = 0 from then on; Out holds 9'h101 stable.
   - raising Out_ready drains 9'h101, 9'h102, then 9'h103 in order.
4. Full FIFO, Out_ready = 1, In1_valid held -> each cycle one pop and one push once count < 2; no combinational Out_ready→In1_ready path (check a mid-cycle Out_ready toggle does not change In1_ready).
5. Only In1 valid for 3 packets, then both valid -> next grant goes to In0 (prio = 0 after In1 wins).
6. Assert _RESET with 2 packets queued -> Out_valid drops immediately and asynchronously; after release the FIFO is empty and no stale packet appears.

Source files
------------

// File: rtl/merge2_arbiter_pkg.sv
// Shared NoC definitions for the merge arbiter.
// Packet width, address field position and FIFO entry layout.
package merge2_arbiter_pkg;

    localparam int PKT_W    = 9;
    localparam int ADDR_MSB = 8;
    localparam int ADDR_LSB = 5;

    typedef struct packed {
        logic             win;
        logic [PKT_W-1:0] data;
    } merge_entry_t;

endpackage

// File: rtl/merge_fifo.sv
// Small synchronous FIFO holding merged packets plus winner tag.
// Ports: CLK, _RESET, push/wr_data in, pop in, rd_data/full/empty out.
module merge_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             _RESET,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/merge2_arbiter.sv
// Round-robin merge of two packet streams onto one upward link.
// Ports: In0/In1 valid-ready inputs, Out valid-ready output with win tag.
module merge2_arbiter
    import merge2_arbiter_pkg::*;
#(
    parameter int W     = PKT_W,
    parameter int DEPTH = 2
) (
    input  logic         CLK,
    input  logic         _RESET,
    input  logic [W-1:0] In0_data,
    input  logic         In0_valid,
    output logic         In0_ready,
    input  logic [W-1:0] In1_data,
    input  logic         In1_valid,
    output logic         In1_ready,
    output logic [W-1:0] Out_data,
    output logic         Out_win,
    output logic         Out_valid,
    input  logic         Out_ready
);

    logic         prio;
    logic         grant;
    logic         grant_idx;
    logic         push;
    logic         full;
    logic         empty;
    logic [W:0]   wr_entry;
    logic [W:0]   rd_entry;

    // Space comes from the registered count only, so ready never
    // sees Out_ready combinationally.
    always_comb begin
        grant     = 1'b0;
        grant_idx = 1'b0;
        if (!full) begin
            if (In0_valid && In1_valid) begin
                grant     = 1'b1;
                grant_idx = prio;
            end else if (In0_valid) begin
                grant     = 1'b1;
                grant_idx = 1'b0;
            end else if (In1_valid) begin
                grant     = 1'b1;
                grant_idx = 1'b1;
            end
        end
    end

    // Readies are held low throughout reset.
    assign In0_ready = _RESET && grant && !grant_idx;
    assign In1_ready = _RESET && grant && grant_idx;
    assign push      = In0_ready || In1_ready;
    assign wr_entry  = {grant_idx, grant_idx ? In1_data : In0_data};

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            prio <= 1'b0;
        end else if (push) begin
            prio <= ~grant_idx;
        end
    end

    merge_fifo #(
        .WIDTH (W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        ._RESET  (_RESET),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (Out_ready),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty)
    );

    assign Out_valid = !empty;
    assign Out_data  = rd_entry[W-1:0];
    assign Out_win   = rd_entry[W];

endmodule

// File: tb/tb_merge2_arbiter.sv
// Directed bench for merge2_arbiter.
// Checks reset, round-robin, backpressure, ready isolation and async reset.
module tb_merge2_arbiter;

    logic       CLK;
    logic       _RESET;
    logic [8:0] in0_d, in1_d, out_d;
    logic       in0_v, in1_v, in0_r, in1_r;
    logic       out_win, out_v, out_r;
    int         n_chk, n_pass;
    logic [8:0] exp_prev;

    merge2_arbiter #(.W(9), .DEPTH(2)) dut (
        .CLK       (CLK),
        ._RESET    (_RESET),
        .In0_data  (in0_d),
        .In0_valid (in0_v),
        .In0_ready (in0_r),
        .In1_data  (in1_d),
        .In1_valid (in1_v),
        .In1_ready (in1_r),
        .Out_data  (out_d),
        .Out_win   (out_win),
        .Out_valid (out_v),
        .Out_ready (out_r)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic chk_out(input string tag, input logic [8:0] d,
                           input logic w);
        check({tag, "_valid"}, 32'(out_v), 32'd1);
        check({tag, "_data"}, 32'(out_d), 32'(d));
        check({tag, "_win"}, 32'(out_win), 32'(w));
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        _RESET = 1'b0;
        in0_v = 1'b1; in0_d = 9'h1A3;
        in1_v = 1'b1; in1_d = 9'h0F2;
        out_r = 1'b1;

        // 1: reset with both inputs valid
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_in0_ready", 32'(in0_r), 0);
            check("rst_in1_ready", 32'(in1_r), 0);
            check("rst_out_valid", 32'(out_v), 0);
            check("rst_out_data", 32'(out_d), 0);
            check("rst_out_win", 32'(out_win), 0);
        end
        _RESET = 1'b1;
        #1;
        check("t1_in0_ready", 32'(in0_r), 1);
        check("t1_in1_ready", 32'(in1_r), 0);
        step();
        chk_out("t1_first", 9'h1A3, 1'b0);
        in0_v = 1'b0;
        #1;
        check("t1_in1_ready", 32'(in1_r), 1);
        step();
        chk_out("t1_second", 9'h0F2, 1'b1);
        in1_v = 1'b0;
        step();
        check("t1_empty", 32'(out_v), 0);

        // 2: both valid, alternate each cycle
        for (int i = 0; i < 8; i++) begin
            step();
            if (i > 0)
                chk_out("t2_out", exp_prev, 1'((i - 1) & 1));
            in0_v = 1'b1; in0_d = 9'(9'h040 + i);
            in1_v = 1'b1; in1_d = 9'(9'h080 + i);
            #1;
            check("t2_in0_ready", 32'(in0_r), 32'((i & 1) == 0));
            check("t2_in1_ready", 32'(in1_r), 32'((i & 1) == 1));
            exp_prev = (i & 1) ? 9'(9'h080 + i) : 9'(9'h040 + i);
        end
        step();
        chk_out("t2_last", exp_prev, 1'b1);
        in0_v = 1'b0; in1_v = 1'b0;
        step();
        check("t2_empty", 32'(out_v), 0);

        // 3: backpressure fills FIFO, then drain in order
        out_r = 1'b0;
        in0_v = 1'b1; in0_d = 9'h101;
        #1;
        check("t3_acc1", 32'(in0_r), 1);
        step();
        chk_out("t3_head1", 9'h101, 1'b0);
        in0_d = 9'h102;
        #1;
        check("t3_acc2", 32'(in0_r), 1);
        step();
        in0_d = 9'h103;
        #1;
        check("t3_full_ready", 32'(in0_r), 0);
        step();
        chk_out("t3_hold", 9'h101, 1'b0);
        check("t3_full_ready2", 32'(in0_r), 0);
        out_r = 1'b1;
        #1;
        check("t3_no_push_at_full", 32'(in0_r), 0);
        step();
        chk_out("t3_drain2", 9'h102, 1'b0);
        check("t3_acc3", 32'(in0_r), 1);
        step();
        chk_out("t3_drain3", 9'h103, 1'b0);
        in0_v = 1'b0;
        step();
        check("t3_empty", 32'(out_v), 0);

        // 4: full FIFO, pop+push, ready isolated from Out_ready
        out_r = 1'b0;
        in1_v = 1'b1; in1_d = 9'h1C1;
        #1;
        check("t4_acc1", 32'(in1_r), 1);
        step();
        chk_out("t4_head", 9'h1C1, 1'b1);
        in1_d = 9'h1C2;
        #1;
        check("t4_acc2", 32'(in1_r), 1);
        step();
        in1_d = 9'h1C3;
        #1;
        check("t4_full_ready", 32'(in1_r), 0);
        out_r = 1'b1;
        #1;
        check("t4_toggle_hi", 32'(in1_r), 0);
        out_r = 1'b0;
        #1;
        check("t4_toggle_lo", 32'(in1_r), 0);
        out_r = 1'b1;
        step();
        chk_out("t4_pop1", 9'h1C2, 1'b1);
        check("t4_ready_c1", 32'(in1_r), 1);
        out_r = 1'b0;
        #1;
        check("t4_toggle_c1", 32'(in1_r), 1);
        out_r = 1'b1;
        step();
        chk_out("t4_pop2", 9'h1C3, 1'b1);
        in1_d = 9'h1C4;
        #1;
        check("t4_ready_c2", 32'(in1_r), 1);
        step();
        chk_out("t4_pop3", 9'h1C4, 1'b1);
        in1_v = 1'b0;
        step();
        check("t4_empty", 32'(out_v), 0);

        // 5: In1 alone, then tie goes to In0
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                step();
                chk_out("t5_in1", 9'(9'h0A0 + k), 1'b1);
            end
            in1_v = 1'b1; in1_d = 9'(9'h0A1 + k);
            #1;
            check("t5_in1_ready", 32'(in1_r), 1);
        end
        step();
        chk_out("t5_in1_last", 9'h0A3, 1'b1);
        in0_v = 1'b1; in0_d = 9'h0B0;
        in1_d = 9'h0B1;
        #1;
        check("t5_tie_in0", 32'(in0_r), 1);
        check("t5_tie_in1", 32'(in1_r), 0);
        step();
        chk_out("t5_b0", 9'h0B0, 1'b0);
        in0_v = 1'b0;
        #1;
        check("t5_next_in1", 32'(in1_r), 1);
        step();
        chk_out("t5_b1", 9'h0B1, 1'b1);
        in1_v = 1'b0;
        step();
        check("t5_empty", 32'(out_v), 0);

        // 6: async reset with two packets queued
        out_r = 1'b0;
        in0_v = 1'b1; in0_d = 9'h111;
        step();
        in0_d = 9'h122;
        step();
        chk_out("t6_queued", 9'h111, 1'b0);
        in1_v = 1'b1; in1_d = 9'h133;
        #2;
        _RESET = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_v), 0);
        check("t6_rst_data", 32'(out_d), 0);
        check("t6_rst_win", 32'(out_win), 0);
        check("t6_rst_in0_ready", 32'(in0_r), 0);
        check("t6_rst_in1_ready", 32'(in1_r), 0);
        step();
        _RESET = 1'b1;
        #1;
        check("t6_prio_in0", 32'(in0_r), 1);
        check("t6_prio_in1", 32'(in1_r), 0);
        in0_v = 1'b0; in1_v = 1'b0;
        out_r = 1'b1;
        step();
        check("t6_no_stale1", 32'(out_v), 0);
        step();
        check("t6_no_stale2", 32'(out_v), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
